// File: rtl/exe_stage_pipe_if.sv
// exe_stage_pipe_if: handshake and datapath bundle between ID/EX, the execute stage and MEM
`timescale 1ns/1ps
interface exe_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int RADDR_W = 5
);
  logic in_valid, in_ready, alu_src, reg_dst, out_valid, out_ready, zero;
  logic [2:0] aluc;
  logic [RADDR_W-1:0] rt_addr, rd_addr, dest_addr;
  logic [XLEN-1:0] rdata1, rdata2, sign_ext, pc_inc, alu_out, br_target, store_data;
  modport master (
    output in_valid, alu_src, reg_dst, aluc, rt_addr, rd_addr, rdata1, rdata2, sign_ext, pc_inc, out_ready,
    input in_ready, out_valid, alu_out, zero, dest_addr, br_target, store_data
  );
  modport slave (
    input in_valid, alu_src, reg_dst, aluc, rt_addr, rd_addr, rdata1, rdata2, sign_ext, pc_inc, out_ready,
    output in_ready, out_valid, alu_out, zero, dest_addr, br_target, store_data
  );
endinterface

// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered MIPS execute stage with valid/ready handshakes and a multi-cycle shift-add MUL
`timescale 1ns/1ps
module exe_stage_pipe #(
  parameter int XLEN = 32,
  parameter int RADDR_W = 5,
  parameter bit MUL_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  exe_stage_pipe_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, MUL, WAIT} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] op_b, res, br, ma, mb, acc, acc_n, m_br, m_sd, sel;
  logic [RADDR_W-1:0] dest, m_dest;
  logic [CW-1:0] cnt;
  logic is_mul, accept, free, last, load_alu, load_mul;
  assign free = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = state == IDLE && free;
  assign accept = bus.in_valid && bus.in_ready;
  assign is_mul = MUL_EN && bus.aluc == 3'b011;
  assign op_b = bus.alu_src ? bus.sign_ext : bus.rdata2;
  assign dest = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
  assign br = bus.pc_inc + (bus.sign_ext << 2);
  assign last = cnt == CW'(XLEN - 1);
  assign acc_n = acc + (mb[0] ? ma : '0);
  assign load_alu = accept && !is_mul;
  assign load_mul = (state == MUL && last && free) || (state == WAIT && bus.out_ready);
  assign sel = load_alu ? res : state == MUL ? acc_n : acc;
  always_comb begin
    res = bus.aluc == 3'b000 ? bus.rdata1 & op_b :
          bus.aluc == 3'b001 ? bus.rdata1 | op_b :
          bus.aluc == 3'b100 ? ~(bus.rdata1 | op_b) :
          bus.aluc == 3'b101 ? bus.rdata1 ^ op_b :
          bus.aluc == 3'b110 ? bus.rdata1 - op_b :
          bus.aluc == 3'b111 ? {{(XLEN-1){1'b0}}, $signed(bus.rdata1) < $signed(op_b)} :
          bus.rdata1 + op_b;
  end
  always_comb begin
    state_n = state == IDLE ? (accept && is_mul ? MUL : IDLE) :
              state == MUL ? (last ? (free ? IDLE : WAIT) : MUL) :
              (bus.out_ready ? IDLE : WAIT);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
      acc <= '0;
      cnt <= '0;
      m_dest <= '0;
      m_br <= '0;
      m_sd <= '0;
      bus.out_valid <= 1'b0;
      bus.alu_out <= '0;
      bus.zero <= 1'b0;
      bus.dest_addr <= '0;
      bus.br_target <= '0;
      bus.store_data <= '0;
    end else begin
      if (accept && is_mul) begin
        ma <= bus.rdata1;
        mb <= op_b;
        acc <= '0;
        cnt <= '0;
        m_dest <= dest;
        m_br <= br;
        m_sd <= bus.rdata2;
      end else if (state == MUL) begin
        acc <= acc_n;
        ma <= ma << 1;
        mb <= mb >> 1;
        cnt <= cnt + CW'(1);
      end
      if (load_alu || load_mul) begin
        bus.out_valid <= 1'b1;
        bus.alu_out <= sel;
        bus.zero <= sel == '0;
        bus.dest_addr <= load_alu ? dest : m_dest;
        bus.br_target <= load_alu ? br : m_br;
        bus.store_data <= load_alu ? bus.rdata2 : m_sd;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb_exe_stage_pipe: directed and randomized self-checking bench for exe_stage_pipe
`timescale 1ns/1ps
module tb_exe_stage_pipe;
  typedef struct {
    logic [31:0] res;
    logic [4:0] dest;
    logic [31:0] br;
    logic [31:0] sd;
  } exp_t;
  logic clk, rst_n;
  int n_cmp, n_bad;
  exp_t q[$];
  logic hold;
  logic [31:0] hold_val;
  exe_stage_pipe_if #(.XLEN(32), .RADDR_W(5)) bus ();
  exe_stage_pipe #(.XLEN(32), .RADDR_W(5), .MUL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic exp_t model(input logic [2:0] op, input logic src, input logic rdst,
                                 input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] a,
                                 input logic [31:0] r2, input logic [31:0] se, input logic [31:0] pc);
    exp_t m;
    logic [31:0] b;
    b = src ? se : r2;
    case (op)
      3'd0: m.res = a & b;
      3'd1: m.res = a | b;
      3'd2: m.res = a + b;
      3'd3: m.res = a * b;
      3'd4: m.res = ~(a | b);
      3'd5: m.res = a ^ b;
      3'd6: m.res = a - b;
      default: m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    m.dest = rdst ? rd : rt;
    m.br = pc + se * 4;
    m.sd = r2;
    return m;
  endfunction
  task automatic drive(input logic [2:0] op, input logic src, input logic [31:0] a,
                       input logic [31:0] r2, input logic [31:0] se, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.aluc = op;
    bus.alu_src = src;
    bus.rdata1 = a;
    bus.rdata2 = r2;
    bus.sign_ext = se;
    bus.pc_inc = pc;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_expected_output", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_alu_out", bus.alu_out, e.res);
        chk("sb_zero", 32'(bus.zero), 32'(e.res == 32'd0));
        chk("sb_dest", 32'(bus.dest_addr), 32'(e.dest));
        chk("sb_br_target", bus.br_target, e.br);
        chk("sb_store_data", bus.store_data, e.sd);
      end
    end
    if (hold) chk("sb_hold_stable", bus.alu_out, hold_val);
    hold = bus.out_valid && !bus.out_ready;
    hold_val = bus.alu_out;
    if (bus.in_valid && bus.in_ready)
      q.push_back(model(bus.aluc, bus.alu_src, bus.reg_dst, bus.rt_addr, bus.rd_addr,
                        bus.rdata1, bus.rdata2, bus.sign_ext, bus.pc_inc));
    step();
  endtask
  initial begin
    logic seen;
    n_cmp = 0;
    n_bad = 0;
    hold = 1'b0;
    hold_val = '0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    bus.reg_dst = 1'b0;
    bus.rt_addr = 5'd3;
    bus.rd_addr = 5'd7;
    drive(3'b010, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0);
    repeat (2) begin
      step();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_alu_out", bus.alu_out, 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd0);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    drive(3'b010, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'h100);
    bus.reg_dst = 1'b1;
    step();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_alu_out", bus.alu_out, 32'd2);
    chk("add_zero", 32'(bus.zero), 32'd0);
    chk("add_br_target", bus.br_target, 32'hF4);
    chk("add_dest", 32'(bus.dest_addr), 32'd7);
    bus.reg_dst = 1'b0;
    drive(3'b110, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0);
    step();
    chk("sub_alu_out", bus.alu_out, 32'd0);
    chk("sub_zero", 32'(bus.zero), 32'd1);
    chk("sub_dest_rt", 32'(bus.dest_addr), 32'd3);
    drive(3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    step();
    chk("slt_alu_out", bus.alu_out, 32'd1);
    drive(3'b100, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    chk("nor_alu_out", bus.alu_out, 32'hFFFF_FFFF);
    drive(3'b011, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("mul_in_ready_low", 32'(bus.in_ready), 32'd0);
      step();
    end
    chk("mul_valid", 32'(bus.out_valid), 32'd1);
    chk("mul_7x6", bus.alu_out, 32'd42);
    drive(3'b011, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    repeat (32) step();
    chk("mul2_valid", 32'(bus.out_valid), 32'd1);
    chk("mul_ffff_x2", bus.alu_out, 32'hFFFF_FFFE);
    step();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    drive(3'b010, 1'b0, 32'd10, 32'd20, 32'd0, 32'd0);
    step();
    chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_first_out", bus.alu_out, 32'd30);
    drive(3'b010, 1'b0, 32'd30, 32'd40, 32'd0, 32'd0);
    repeat (3) begin
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      step();
      chk("bp_stable", bus.alu_out, 32'd30);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_second_out", bus.alu_out, 32'd70);
    chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
    drive(3'b010, 1'b0, 32'd100, 32'd5, 32'd0, 32'd0);
    step();
    chk("bp_third_out", bus.alu_out, 32'd105);
    bus.in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    drive(3'b011, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    drive(3'b010, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0);
    step();
    chk("postrst_add_valid", 32'(bus.out_valid), 32'd1);
    chk("postrst_add", bus.alu_out, 32'd2);
    bus.in_valid = 1'b0;
    step();
    q.delete();
    hold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.aluc = 3'($urandom_range(0, 7));
      bus.alu_src = 1'($urandom);
      bus.reg_dst = 1'($urandom);
      bus.rt_addr = 5'($urandom);
      bus.rd_addr = 5'($urandom);
      bus.rdata1 = $urandom;
      bus.rdata2 = $urandom_range(0, 3) == 0 ? bus.rdata1 : $urandom;
      bus.sign_ext = $urandom_range(0, 1) == 0 ? 32'($signed($urandom_range(0, 65535) - 32768)) : bus.rdata2;
      bus.pc_inc = $urandom;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (60) tick();
    chk("sb_all_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
